// File: rtl/atmr_vote_monitor.sv
// Registered bitwise TMR voter for the ori/mai/men replicas.
// It keeps per-replica persistence FSMs and saturating error counters, and falls back to two-replica operation once a replica is faulty.
module atmr_vote_monitor #(
   parameter int WIDTH   = 10,
   parameter int CNT_W   = 8,
   parameter int PERSIST = 4,
   parameter int DEGRADE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] ori_in,
   input  logic [WIDTH-1:0] mai_in,
   input  logic [WIDTH-1:0] men_in,
   input  logic             clr,
   output logic [WIDTH-1:0] vote_out,
   output logic             out_valid,
   output logic [WIDTH-1:0] mism_mask,
   output logic [2:0]       rep_err,
   output logic [2:0]       faulty,
   output logic             dual_mismatch,
   output logic             fatal,
   output logic [CNT_W-1:0] err_cnt_ori,
   output logic [CNT_W-1:0] err_cnt_mai,
   output logic [CNT_W-1:0] err_cnt_men
);

   // State 0 is OK, 1..PERSIST-1 count consecutive mismatches (SUSPECT), 15 is FAULTY.
   localparam logic [3:0] ST_OK     = 4'd0;
   localparam logic [3:0] ST_FAULTY = 4'd15;
   localparam logic [4:0] PERSIST_W = 5'(PERSIST);

   function automatic logic [WIDTH-1:0] majority(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [WIDTH-1:0] c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic [3:0] fsm_next(input logic [3:0] st, input logic mis);
      logic [3:0] nxt;
      nxt = st;
      if (st == ST_FAULTY) begin
         nxt = ST_FAULTY;
      end else if (!mis) begin
         nxt = ST_OK;
      end else if (({1'b0, st} + 5'd1) >= PERSIST_W) begin
         nxt = ST_FAULTY;
      end else begin
         nxt = st + 4'd1;
      end
      return nxt;
   endfunction

   logic [2:0][WIDTH-1:0] rep_w;
   logic [WIDTH-1:0]      maj;
   logic [2:0]            mis;
   logic [1:0]            nfaulty;
   logic [WIDTH-1:0]      healthy_a;
   logic [WIDTH-1:0]      healthy_b;

   logic [WIDTH-1:0]      vote_d, vote_q;
   logic                  out_valid_d, out_valid_q;
   logic [WIDTH-1:0]      mism_d, mism_q;
   logic [2:0]            rep_err_d, rep_err_q;
   logic                  dual_d, dual_q;
   logic                  fatal_d, fatal_q;
   logic [2:0][3:0]       st_d, st_q;
   logic [2:0][CNT_W-1:0] cnt_d, cnt_q;

   assign rep_w = {men_in, mai_in, ori_in};
   assign maj   = majority(ori_in, mai_in, men_in);

   always_comb begin
      for (int r = 0; r < 3; r++) begin
         mis[r]    = |(rep_w[r] ^ maj);
         faulty[r] = (st_q[r] == ST_FAULTY);
      end
      nfaulty = {1'b0, faulty[0]} + {1'b0, faulty[1]} + {1'b0, faulty[2]};
   end

   // The lower-indexed healthy replica drives the output in degraded mode.
   always_comb begin
      healthy_a = ori_in;
      healthy_b = mai_in;
      if (faulty[0]) begin
         healthy_a = mai_in;
         healthy_b = men_in;
      end else if (faulty[1]) begin
         healthy_a = ori_in;
         healthy_b = men_in;
      end
   end

   always_comb begin
      vote_d      = vote_q;
      out_valid_d = in_valid;
      mism_d      = mism_q;
      rep_err_d   = rep_err_q;
      dual_d      = dual_q;
      fatal_d     = fatal_q | (nfaulty >= 2'd2);
      st_d        = st_q;
      cnt_d       = cnt_q;

      if (in_valid) begin
         mism_d    = ~((ori_in & mai_in & men_in) | (~ori_in & ~mai_in & ~men_in));
         rep_err_d = mis;
         vote_d    = maj;
         dual_d    = 1'b0;
         if ((DEGRADE != 0) && (nfaulty == 2'd1)) begin
            vote_d = healthy_a;
            dual_d = (healthy_a != healthy_b);
         end
         for (int r = 0; r < 3; r++) begin
            if (mis[r]) begin
               cnt_d[r] = sat_inc(cnt_q[r]);
            end
            st_d[r] = fsm_next(st_q[r], mis[r]);
         end
      end

      // Clear wins over any mismatch seen in the same cycle.
      if (clr) begin
         fatal_d = 1'b0;
         for (int r = 0; r < 3; r++) begin
            st_d[r]  = ST_OK;
            cnt_d[r] = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vote_q      <= '0;
         out_valid_q <= 1'b0;
         mism_q      <= '0;
         rep_err_q   <= '0;
         dual_q      <= 1'b0;
         fatal_q     <= 1'b0;
         st_q        <= '0;
         cnt_q       <= '0;
      end else begin
         vote_q      <= vote_d;
         out_valid_q <= out_valid_d;
         mism_q      <= mism_d;
         rep_err_q   <= rep_err_d;
         dual_q      <= dual_d;
         fatal_q     <= fatal_d;
         st_q        <= st_d;
         cnt_q       <= cnt_d;
      end
   end

   assign vote_out      = vote_q;
   assign out_valid     = out_valid_q;
   assign mism_mask     = mism_q;
   assign rep_err       = rep_err_q;
   assign dual_mismatch = dual_q;
   assign fatal         = fatal_q;
   assign err_cnt_ori   = cnt_q[0];
   assign err_cnt_mai   = cnt_q[1];
   assign err_cnt_men   = cnt_q[2];

endmodule

// File: tb/tb_atmr_vote_monitor.sv
// Directed bench for atmr_vote_monitor: u0 uses the default parameters; u1 uses CNT_W=3 and DEGRADE=0.
// Both instances share the same stimulus.
module tb_atmr_vote_monitor;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [9:0] ori, mai, men;
   logic       clr;

   logic [9:0] v0_vote, v0_mism, v1_vote, v1_mism;
   logic       v0_ov, v0_dual, v0_fatal, v1_ov, v1_dual, v1_fatal;
   logic [2:0] v0_rep, v0_flt, v1_rep, v1_flt;
   logic [7:0] v0_co, v0_ca, v0_cn;
   logic [2:0] v1_co, v1_ca, v1_cn;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   atmr_vote_monitor #(.WIDTH(10), .CNT_W(8), .PERSIST(4), .DEGRADE(1)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .ori_in(ori), .mai_in(mai), .men_in(men),
      .clr(clr), .vote_out(v0_vote), .out_valid(v0_ov), .mism_mask(v0_mism), .rep_err(v0_rep),
      .faulty(v0_flt), .dual_mismatch(v0_dual), .fatal(v0_fatal),
      .err_cnt_ori(v0_co), .err_cnt_mai(v0_ca), .err_cnt_men(v0_cn));

   atmr_vote_monitor #(.WIDTH(10), .CNT_W(3), .PERSIST(4), .DEGRADE(0)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .ori_in(ori), .mai_in(mai), .men_in(men),
      .clr(clr), .vote_out(v1_vote), .out_valid(v1_ov), .mism_mask(v1_mism), .rep_err(v1_rep),
      .faulty(v1_flt), .dual_mismatch(v1_dual), .fatal(v1_fatal),
      .err_cnt_ori(v1_co), .err_cnt_mai(v1_ca), .err_cnt_men(v1_cn));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic v, input logic [9:0] o, input logic [9:0] m,
                       input logic [9:0] n, input logic c);
      @(negedge clk);
      in_valid = v;
      ori = o;
      mai = m;
      men = n;
      clr = c;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_vote0"}, {22'd0, v0_vote}, 32'h0);
      chk({tag, "_ov0"}, {31'd0, v0_ov}, 32'h0);
      chk({tag, "_mism0"}, {22'd0, v0_mism}, 32'h0);
      chk({tag, "_rep0"}, {29'd0, v0_rep}, 32'h0);
      chk({tag, "_flt0"}, {29'd0, v0_flt}, 32'h0);
      chk({tag, "_fatal0"}, {31'd0, v0_fatal}, 32'h0);
      chk({tag, "_cnt0"}, {8'd0, v0_co, v0_ca, v0_cn}, 32'h0);
      chk({tag, "_flt1"}, {29'd0, v1_flt}, 32'h0);
      chk({tag, "_fatal1"}, {31'd0, v1_fatal}, 32'h0);
      chk({tag, "_cnt1"}, {23'd0, v1_co, v1_ca, v1_cn}, 32'h0);
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      ori = '0;
      mai = '0;
      men = '0;
      clr = 1'b0;
      #3;
      chk_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // Unanimous stream
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 10'h2A5, 10'h2A5, 10'h2A5, 1'b0);
         chk("unan_vote", {22'd0, v0_vote}, 32'h2A5);
         chk("unan_ov", {31'd0, v0_ov}, 32'h1);
      end
      chk("unan_mism", {22'd0, v0_mism}, 32'h0);
      chk("unan_cnt", {8'd0, v0_co, v0_ca, v0_cn}, 32'h0);
      chk("unan_flt", {29'd0, v0_flt}, 32'h0);

      // Single-bit flip on mai
      step(1'b1, 10'h2A5, 10'h2A4, 10'h2A5, 1'b0);
      chk("flip_vote", {22'd0, v0_vote}, 32'h2A5);
      chk("flip_mism", {22'd0, v0_mism}, 32'h001);
      chk("flip_rep", {29'd0, v0_rep}, 32'h2);
      chk("flip_cnt_mai", {24'd0, v0_ca}, 32'h1);
      chk("flip_flt", {29'd0, v0_flt}, 32'h0);

      // Invalid cycle: registered outputs hold, state frozen
      step(1'b0, 10'h3FF, 10'h000, 10'h155, 1'b0);
      chk("hold_ov", {31'd0, v0_ov}, 32'h0);
      chk("hold_vote", {22'd0, v0_vote}, 32'h2A5);
      chk("hold_mism", {22'd0, v0_mism}, 32'h001);
      chk("hold_rep", {29'd0, v0_rep}, 32'h2);
      chk("hold_cnt", {8'd0, v0_co, v0_ca, v0_cn}, 32'h000100);

      // Persistence: men wrong 3, right 1, wrong 4
      for (int i = 0; i < 3; i++) step(1'b1, 10'h2A5, 10'h2A5, 10'h2A7, 1'b0);
      step(1'b1, 10'h2A5, 10'h2A5, 10'h2A5, 1'b0);
      chk("pers_after_match", {29'd0, v0_flt}, 32'h0);
      for (int i = 0; i < 3; i++) step(1'b1, 10'h2A5, 10'h2A5, 10'h2A7, 1'b0);
      chk("pers_3rd", {29'd0, v0_flt}, 32'h0);
      step(1'b1, 10'h2A5, 10'h2A5, 10'h2A7, 1'b0);
      chk("pers_4th_flt0", {29'd0, v0_flt}, 32'h4);
      chk("pers_4th_flt1", {29'd0, v1_flt}, 32'h4);
      chk("pers_cnt_men0", {24'd0, v0_cn}, 32'h7);
      chk("pers_cnt_men1", {29'd0, v1_cn}, 32'h7);
      chk("pers_cnt_mai0", {24'd0, v0_ca}, 32'h1);
      chk("pers_fatal", {31'd0, v0_fatal}, 32'h0);

      // Degraded mode with men faulty
      step(1'b1, 10'h00F, 10'h0F0, 10'h0F0, 1'b0);
      chk("deg_vote0", {22'd0, v0_vote}, 32'h00F);
      chk("deg_dual0", {31'd0, v0_dual}, 32'h1);
      chk("deg_vote1", {22'd0, v1_vote}, 32'h0F0);
      chk("deg_dual1", {31'd0, v1_dual}, 32'h0);
      chk("deg_mism", {22'd0, v0_mism}, 32'h0FF);
      chk("deg_rep", {29'd0, v0_rep}, 32'h1);
      chk("deg_cnt_ori", {24'd0, v0_co}, 32'h1);
      step(1'b1, 10'h133, 10'h133, 10'h000, 1'b0);
      chk("deg_eq_vote0", {22'd0, v0_vote}, 32'h133);
      chk("deg_eq_dual0", {31'd0, v0_dual}, 32'h0);
      chk("deg_eq_flt0", {29'd0, v0_flt}, 32'h4);

      // clr cycle: output still selected from the pre-clear faulty state
      step(1'b1, 10'h001, 10'h002, 10'h002, 1'b1);
      chk("clr_vote0", {22'd0, v0_vote}, 32'h001);
      chk("clr_dual0", {31'd0, v0_dual}, 32'h1);
      chk("clr_vote1", {22'd0, v1_vote}, 32'h002);
      chk("clr_rep", {29'd0, v0_rep}, 32'h1);
      chk("clr_flt", {29'd0, v0_flt}, 32'h0);
      chk("clr_cnt0", {8'd0, v0_co, v0_ca, v0_cn}, 32'h0);
      chk("clr_cnt1", {23'd0, v1_co, v1_ca, v1_cn}, 32'h0);

      // Saturation: ori wrong 10 cycles
      step(1'b0, 10'h000, 10'h000, 10'h000, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 10'h3FF, 10'h000, 10'h000, 1'b0);
      chk("sat_3rd_flt", {29'd0, v0_flt}, 32'h0);
      step(1'b1, 10'h3FF, 10'h000, 10'h000, 1'b0);
      chk("sat_4th_flt", {29'd0, v0_flt}, 32'h1);
      for (int i = 0; i < 6; i++) step(1'b1, 10'h3FF, 10'h000, 10'h000, 1'b0);
      chk("sat_cnt0", {24'd0, v0_co}, 32'hA);
      chk("sat_cnt1", {29'd0, v1_co}, 32'h7);
      chk("sat_vote0", {22'd0, v0_vote}, 32'h000);
      chk("sat_fatal", {31'd0, v0_fatal}, 32'h0);
      step(1'b1, 10'h3FF, 10'h000, 10'h000, 1'b1);
      chk("satclr_cnt0", {24'd0, v0_co}, 32'h0);
      chk("satclr_cnt1", {29'd0, v1_co}, 32'h0);
      chk("satclr_flt", {29'd0, v0_flt | v1_flt}, 32'h0);
      chk("satclr_fatal", {31'd0, v0_fatal | v1_fatal}, 32'h0);

      // Fatal: ori and mai both faulty
      for (int i = 0; i < 4; i++) step(1'b1, 10'h001, 10'h002, 10'h000, 1'b0);
      chk("fat_flt0", {29'd0, v0_flt}, 32'h3);
      chk("fat_pre0", {31'd0, v0_fatal}, 32'h0);
      chk("fat_cnt_ori", {24'd0, v0_co}, 32'h4);
      step(1'b1, 10'h001, 10'h002, 10'h000, 1'b0);
      chk("fat_set0", {31'd0, v0_fatal}, 32'h1);
      chk("fat_set1", {31'd0, v1_fatal}, 32'h1);
      chk("fat_vote0", {22'd0, v0_vote}, 32'h000);

      // Asynchronous reset mid-cycle
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk_all_zero("async_rst");
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 10'h155, 10'h155, 10'h155, 1'b0);
      chk("post_rst_ov", {31'd0, v0_ov}, 32'h0);
      step(1'b1, 10'h155, 10'h155, 10'h155, 1'b0);
      chk("post_rst_ov1", {31'd0, v0_ov}, 32'h1);
      chk("post_rst_vote", {22'd0, v0_vote}, 32'h155);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
